// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX and RX cores on the same serial link.
package uart_pkg;

  localparam int UART_STATE_SIZE = 3;

  // Cycles per bit for a 50 MHz system clock.
  localparam int CPB_115200 = 434;
  localparam int CPB_57600  = 868;
  localparam int CPB_19200  = 2604;
  localparam int CPB_9600   = 5208;

  typedef enum logic [UART_STATE_SIZE-1:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4,
    BREAK = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle between the board RX pin, the receiver and user logic.
interface uart_rx_if #(
  parameter int DATAWIDTH_BUS = 8
);

  logic                     UART_RX_rx_In;
  logic [DATAWIDTH_BUS-1:0] UART_RX_data_Out;
  logic                     UART_RX_newData_Out;
  logic                     UART_RX_frameError_Out;
  logic                     UART_RX_busy_Out;

  modport master (
    output UART_RX_rx_In,
    input  UART_RX_data_Out,
    input  UART_RX_newData_Out,
    input  UART_RX_frameError_Out,
    input  UART_RX_busy_Out
  );

  modport slave (
    input  UART_RX_rx_In,
    output UART_RX_data_Out,
    output UART_RX_newData_Out,
    output UART_RX_frameError_Out,
    output UART_RX_busy_Out
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Metastability filter chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      q_r    <= 1'b1;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle newData strobe, stop-bit framing error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = CPB_115200,
  parameter int DATAWIDTH_BUS = 8,
  parameter int STATE_SIZE    = UART_STATE_SIZE
) (
  input  logic     UART_RX_CLOCK_50,
  input  logic     UART_RX_RESET_InLow,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLOCK_PER_BIT);
  localparam int IDX_W = $clog2(DATAWIDTH_BUS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLOCK_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATAWIDTH_BUS - 1);

  logic                     rx_s;
  logic [STATE_SIZE-1:0]    state_r;
  uart_state_t              state_nxt_s;
  logic [CNT_W-1:0]         clk_cnt_r,  clk_cnt_nxt_s;
  logic [IDX_W-1:0]         bit_idx_r,  bit_idx_nxt_s;
  logic [DATAWIDTH_BUS-1:0] sr_r,       sr_nxt_s;
  logic [DATAWIDTH_BUS-1:0] data_r,     data_nxt_s;
  logic                     new_data_r, new_data_nxt_s;
  logic                     frame_err_r, frame_err_nxt_s;
  logic                     busy_r;

  uart_rx_sync u_sync (
    .clk   (UART_RX_CLOCK_50),
    .rst_n (UART_RX_RESET_InLow),
    .d     (bus.UART_RX_rx_In),
    .q     (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge UART_RX_CLOCK_50 or negedge UART_RX_RESET_InLow) begin
    if (!UART_RX_RESET_InLow) begin
      state_r     <= STATE_SIZE'(IDLE);
      clk_cnt_r   <= {CNT_W{1'b0}};
      bit_idx_r   <= {IDX_W{1'b0}};
      sr_r        <= {DATAWIDTH_BUS{1'b0}};
      data_r      <= {DATAWIDTH_BUS{1'b0}};
      new_data_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= STATE_SIZE'(state_nxt_s);
      clk_cnt_r   <= clk_cnt_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      sr_r        <= sr_nxt_s;
      data_r      <= data_nxt_s;
      new_data_r  <= new_data_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_nxt_s     = IDLE;
    clk_cnt_nxt_s   = clk_cnt_r + CNT_W'(1);
    bit_idx_nxt_s   = bit_idx_r;
    sr_nxt_s        = sr_r;
    data_nxt_s      = data_r;
    new_data_nxt_s  = 1'b0;
    frame_err_nxt_s = frame_err_r;

    case (uart_state_t'(state_r))
      IDLE: begin
        clk_cnt_nxt_s = {CNT_W{1'b0}};
        bit_idx_nxt_s = {IDX_W{1'b0}};
        if (!rx_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      START: begin
        if (clk_cnt_r == CNT_HALF) begin
          clk_cnt_nxt_s = {CNT_W{1'b0}};
          if (!rx_s) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = START;
        end
      end

      DATA: begin
        if (clk_cnt_r == CNT_LAST) begin
          clk_cnt_nxt_s = {CNT_W{1'b0}};
          sr_nxt_s      = {rx_s, sr_r[DATAWIDTH_BUS-1:1]};
          if (bit_idx_r == IDX_LAST) begin
            state_nxt_s = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + IDX_W'(1);
            state_nxt_s   = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end

      STOP: begin
        if (clk_cnt_r == CNT_LAST) begin
          clk_cnt_nxt_s = {CNT_W{1'b0}};
          if (rx_s) begin
            data_nxt_s      = sr_r;
            new_data_nxt_s  = 1'b1;
            frame_err_nxt_s = 1'b0;
            state_nxt_s     = DONE;
          end else begin
            frame_err_nxt_s = 1'b1;
            state_nxt_s     = BREAK;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end

      DONE: begin
        clk_cnt_nxt_s = {CNT_W{1'b0}};
        bit_idx_nxt_s = {IDX_W{1'b0}};
        state_nxt_s   = IDLE;
      end

      // Hold off re-triggering until the line returns high after a break.
      BREAK: begin
        clk_cnt_nxt_s = {CNT_W{1'b0}};
        bit_idx_nxt_s = {IDX_W{1'b0}};
        if (rx_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BREAK;
        end
      end

      default: begin
        clk_cnt_nxt_s = {CNT_W{1'b0}};
        bit_idx_nxt_s = {IDX_W{1'b0}};
        state_nxt_s   = IDLE;
      end
    endcase
  end

  assign bus.UART_RX_data_Out       = data_r;
  assign bus.UART_RX_newData_Out    = new_data_r;
  assign bus.UART_RX_frameError_Out = frame_err_r;
  assign bus.UART_RX_busy_Out       = busy_r;

endmodule
